cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares one memory-side request/return port between the instruction cache (read-only) and the data cache (read plus line write-back).
- Uses the same rd_req/rd_rdy/ret_valid/ret_last and wr_req/wr_rdy handshake the caches already drive; sits between the two caches and the memory/AXI bridge.
- Allows one outstanding read, plus one buffered write with a read-after-write line hazard check.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, write-back line width.
- BEAT_W, 32, read return beat width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ic_rd_req  in  1  icache read request
- ic_rd_type  in  3  icache read type (3'b100 = line)
- ic_rd_addr  in  ADDR_W  icache read address
- ic_rd_rdy  out  1  icache read accepted
- ic_ret_valid  out  1  icache return beat valid
- ic_ret_last  out  1  icache last beat
- ic_ret_data  out  BEAT_W  icache return data
- dc_rd_req / dc_rd_type / dc_rd_addr / dc_rd_rdy / dc_ret_valid / dc_ret_last / dc_ret_data  -, same as ic_* for the dcache
- dc_wr_req  in  1  dcache write request
- dc_wr_type  in  3  write type
- dc_wr_addr  in  ADDR_W  write address
- dc_wr_wstrb  in  4  byte strobe
- dc_wr_data  in  LINE_W  write data
- dc_wr_rdy  out  1  write accepted
- m_rd_req  out  1  memory read request
- m_rd_type  out  3  memory read type
- m_rd_addr  out  ADDR_W  memory read address
- m_rd_rdy  in  1  memory read accepted
- m_ret_valid  in  1  memory return valid
- m_ret_last  in  1  memory last beat
- m_ret_data  in  BEAT_W  memory return data
- m_wr_req  out  1  memory write request
- m_wr_type  out  3  memory write type
- m_wr_addr  out  ADDR_W  memory write address
- m_wr_wstrb  out  4  memory byte strobe
- m_wr_data  out  LINE_W  memory write data
- m_wr_rdy  in  1  memory write accepted
- m_wr_done  in  1  memory write response (write complete)

Behaviour:
- Reset: clk, reset is synchronous active-high. On reset both FSMs go idle and every output is 0, including data/address buses.
- Read FSM states: R_IDLE, R_REQ, R_DATA.
- R_IDLE arbitration:
  - Grant to dcache if dc_rd_req and not hazard; otherwise to icache if ic_rd_req; otherwise stay idle.
  - Hazard = write FSM not W_IDLE and dc_rd_addr[ADDR_W-1:4] == wbuf_addr[ADDR_W-1:4].
  - On grant: latch owner, type and addr; go to R_REQ. The granted requester's *_rd_rdy pulses for 1 cycle in that same cycle.
  - ic_rd_rdy and dc_rd_rdy are never both 1.
- R_REQ: m_rd_req=1 with the latched type/addr, held stable until m_rd_rdy, then go to R_DATA.
- R_DATA:
  - m_ret_valid/last/data are routed combinationally to the owner's ret_* outputs; the other requester sees ret_valid=0.
  - m_ret_valid & m_ret_last returns to R_IDLE; a new grant is possible the next cycle.
  - A beat counter (2 bits) counts returned beats. A last beat with counter != 3 for type 3'b100, or != 0 for other types, is a protocol error; it is reported only by the debug output.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
- W_IDLE:
  - dc_wr_rdy=1.
  - dc_wr_req latches addr/type/wstrb/data into wbuf and goes to W_REQ.
- W_REQ: m_wr_req=1 from wbuf, stable until m_wr_rdy, then go to W_RESP.
- W_RESP: wait for m_wr_done, then go to W_IDLE. dc_wr_rdy=0 in W_REQ and W_RESP.
- Concurrency and ordering:
  - Read and write FSMs run concurrently.
  - A read to a different line may overtake the buffered write.
  - An icache read is never hazard-checked (no self-modifying code support).
- Simultaneous cases:
  - dc_wr_req and a hazarding dc_rd_req in the same cycle: the write is accepted and the read is blocked.
  - m_wr_done while in W_REQ is ignored.
- Reset mid-transaction abandons it; outstanding memory returns after reset are dropped (R_IDLE ignores m_ret_valid).

Optional Feature:
- RR_ARB_EN defined: the R_IDLE arbitration is round-robin. A 1-bit last_owner register gives priority to the requester not granted last; last_owner resets to icache, so dcache wins the first tie.
- RR_ARB_EN undefined: fixed priority, dcache over icache.
- The hazard block applies in both modes.

Test Plan:
- Single icache line read at 0x1c000000: m_rd_req with addr 0x1c000000, type 3'b100; 4 beats 0x11,0x22,0x33,0x44 -> appear only on ic_ret_data; ic_ret_last on 4th; dc_ret_valid stays 0.
- ic_rd_req and dc_rd_req same cycle, addrs 0x100/0x200, no RR_ARB_EN -> dcache granted first (m_rd_addr=0x200), icache served after its last beat; with RR_ARB_EN the second tie alternates.
- dc_wr_req addr 0x00001230, data 0xAABB...; m_wr_done delayed 10 cycles; dc_rd_req 0x00001238 -> read blocked, m_rd_req=0 until cycle after m_wr_done; read to 0x00002000 proceeds immediately.
- m_rd_rdy held low 5 cycles -> m_rd_req and m_rd_addr stable all 5 cycles; only one rd_rdy pulse to the requester.
- Second dc_wr_req while in W_RESP -> dc_wr_rdy=0 until m_wr_done; then the request is accepted.
- Assert reset during R_DATA after 2 beats -> all outputs 0 next cycle; stray m_ret_valid afterwards produces no ic/dc ret_valid.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between cache_mem_arbiter and its neighbours (icache, dcache, memory bridge).
// slave = the arbiter's view; master = the view of the caches and memory around it.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int BEAT_W = 32
) ();
  logic              ic_rd_req;
  logic [2:0]        ic_rd_type;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic              ic_rd_rdy;
  logic              ic_ret_valid;
  logic              ic_ret_last;
  logic [BEAT_W-1:0] ic_ret_data;

  logic              dc_rd_req;
  logic [2:0]        dc_rd_type;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_rd_rdy;
  logic              dc_ret_valid;
  logic              dc_ret_last;
  logic [BEAT_W-1:0] dc_ret_data;

  logic              dc_wr_req;
  logic [2:0]        dc_wr_type;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [3:0]        dc_wr_wstrb;
  logic [LINE_W-1:0] dc_wr_data;
  logic              dc_wr_rdy;

  logic              m_rd_req;
  logic [2:0]        m_rd_type;
  logic [ADDR_W-1:0] m_rd_addr;
  logic              m_rd_rdy;
  logic              m_ret_valid;
  logic              m_ret_last;
  logic [BEAT_W-1:0] m_ret_data;

  logic              m_wr_req;
  logic [2:0]        m_wr_type;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [3:0]        m_wr_wstrb;
  logic [LINE_W-1:0] m_wr_data;
  logic              m_wr_rdy;
  logic              m_wr_done;

  // Pulses for one cycle when a read burst ends on an unexpected beat count.
  logic              dbg_proto_err;

  modport slave (
    input  ic_rd_req, ic_rd_type, ic_rd_addr,
    output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
    input  dc_rd_req, dc_rd_type, dc_rd_addr,
    output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
    input  dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    output dc_wr_rdy,
    output m_rd_req, m_rd_type, m_rd_addr,
    input  m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
    output m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
    input  m_wr_rdy, m_wr_done,
    output dbg_proto_err
  );

  modport master (
    output ic_rd_req, ic_rd_type, ic_rd_addr,
    input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
    output dc_rd_req, dc_rd_type, dc_rd_addr,
    input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
    output dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    input  dc_wr_rdy,
    input  m_rd_req, m_rd_type, m_rd_addr,
    output m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
    input  m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
    output m_wr_rdy, m_wr_done,
    input  dbg_proto_err
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache reads and dcache reads/write-backs: one outstanding
// read plus one buffered write with a line hazard check. Define RR_ARB_EN for round-robin reads.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int BEAT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  cache_mem_arbiter_if.slave bus
);
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [2:0] TYPE_LINE = 3'b100;
  localparam logic       OWN_IC = 1'b0;
  localparam logic       OWN_DC = 1'b1;

  logic [1:0]        r_state_reg, r_state_next;
  logic              owner_reg;
  logic [2:0]        rd_type_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [1:0]        beat_cnt_reg;
  logic              proto_err_reg;

  logic [1:0]        w_state_reg, w_state_next;
  logic [2:0]        wbuf_type_reg;
  logic [ADDR_W-1:0] wbuf_addr_reg;
  logic [3:0]        wbuf_wstrb_reg;
  logic [LINE_W-1:0] wbuf_data_reg;

  logic hazard, dc_cand, ic_cand, pick_dc, grant;
  logic last_beat, beat_cnt_bad, wbuf_load, data_phase;

  // A dcache read must not pass a buffered write to the same 16-byte line, including
  // a write being accepted in this very cycle.
  always_comb begin
    hazard = 1'b0;
    if ((w_state_reg != W_IDLE) &&
        (bus.dc_rd_addr[ADDR_W-1:4] == wbuf_addr_reg[ADDR_W-1:4]))
      hazard = 1'b1;
    if ((w_state_reg == W_IDLE) && bus.dc_wr_req &&
        (bus.dc_rd_addr[ADDR_W-1:4] == bus.dc_wr_addr[ADDR_W-1:4]))
      hazard = 1'b1;
  end

  assign dc_cand = bus.dc_rd_req && !hazard;
  assign ic_cand = bus.ic_rd_req;
  assign grant   = (r_state_reg == R_IDLE) && !reset && (dc_cand || ic_cand);

`ifdef RR_ARB_EN
  logic last_owner_reg;

  // On a tie the requester that was not granted last wins.
  assign pick_dc = dc_cand && (!ic_cand || (last_owner_reg == OWN_IC));

  always_ff @(posedge clk) begin
    if (reset)
      last_owner_reg <= OWN_IC;
    else if (grant)
      last_owner_reg <= pick_dc ? OWN_DC : OWN_IC;
  end
`else
  assign pick_dc = dc_cand;
`endif

  assign bus.dc_rd_rdy = grant && pick_dc;
  assign bus.ic_rd_rdy = grant && !pick_dc;

  assign last_beat    = (r_state_reg == R_DATA) && bus.m_ret_valid && bus.m_ret_last;
  assign beat_cnt_bad = (rd_type_reg == TYPE_LINE) ? (beat_cnt_reg != 2'd3)
                                                   : (beat_cnt_reg != 2'd0);

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (grant) r_state_next = R_REQ;
      R_REQ:   if (bus.m_rd_rdy) r_state_next = R_DATA;
      R_DATA:  if (last_beat) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_reg   <= R_IDLE;
      owner_reg     <= OWN_IC;
      rd_type_reg   <= 3'd0;
      rd_addr_reg   <= '0;
      beat_cnt_reg  <= 2'd0;
      proto_err_reg <= 1'b0;
    end else begin
      r_state_reg   <= r_state_next;
      proto_err_reg <= last_beat && beat_cnt_bad;
      if (grant) begin
        owner_reg    <= pick_dc ? OWN_DC : OWN_IC;
        rd_type_reg  <= pick_dc ? bus.dc_rd_type : bus.ic_rd_type;
        rd_addr_reg  <= pick_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
        beat_cnt_reg <= 2'd0;
      end else if ((r_state_reg == R_DATA) && bus.m_ret_valid) begin
        beat_cnt_reg <= beat_cnt_reg + 2'd1;
      end
    end
  end

  assign bus.m_rd_req      = (r_state_reg == R_REQ) && !reset;
  assign bus.m_rd_type     = rd_type_reg;
  assign bus.m_rd_addr     = rd_addr_reg;
  assign bus.dbg_proto_err = proto_err_reg;

  // Returns go straight through to whoever owns the outstanding read; the other side sees nothing.
  assign data_phase       = (r_state_reg == R_DATA) && !reset;
  assign bus.ic_ret_valid = data_phase && (owner_reg == OWN_IC) && bus.m_ret_valid;
  assign bus.ic_ret_last  = bus.ic_ret_valid && bus.m_ret_last;
  assign bus.ic_ret_data  = (data_phase && (owner_reg == OWN_IC)) ? bus.m_ret_data : {BEAT_W{1'b0}};
  assign bus.dc_ret_valid = data_phase && (owner_reg == OWN_DC) && bus.m_ret_valid;
  assign bus.dc_ret_last  = bus.dc_ret_valid && bus.m_ret_last;
  assign bus.dc_ret_data  = (data_phase && (owner_reg == OWN_DC)) ? bus.m_ret_data : {BEAT_W{1'b0}};

  assign wbuf_load = (w_state_reg == W_IDLE) && bus.dc_wr_req;

  // m_wr_done only counts once the bridge has taken the write (W_RESP).
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (bus.dc_wr_req) w_state_next = W_REQ;
      W_REQ:   if (bus.m_wr_rdy) w_state_next = W_RESP;
      W_RESP:  if (bus.m_wr_done) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_reg    <= W_IDLE;
      wbuf_type_reg  <= 3'd0;
      wbuf_addr_reg  <= '0;
      wbuf_wstrb_reg <= 4'd0;
      wbuf_data_reg  <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (wbuf_load) begin
        wbuf_type_reg  <= bus.dc_wr_type;
        wbuf_addr_reg  <= bus.dc_wr_addr;
        wbuf_wstrb_reg <= bus.dc_wr_wstrb;
        wbuf_data_reg  <= bus.dc_wr_data;
      end
    end
  end

  assign bus.dc_wr_rdy  = (w_state_reg == W_IDLE) && !reset;
  assign bus.m_wr_req   = (w_state_reg == W_REQ) && !reset;
  assign bus.m_wr_type  = wbuf_type_reg;
  assign bus.m_wr_addr  = wbuf_addr_reg;
  assign bus.m_wr_wstrb = wbuf_wstrb_reg;
  assign bus.m_wr_data  = wbuf_data_reg;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table-driven reads with a return-beat scoreboard,
// plus hand-written sequences for arbitration ties, write hazards and reset mid-burst.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int BEAT_W = 32;
`ifdef RR_ARB_EN
  localparam bit SECOND_DC = 1'b0;
`else
  localparam bit SECOND_DC = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int ic_rdy_cnt = 0;
  int dc_rdy_cnt = 0;
  int err_cnt = 0;

  typedef struct { bit dc; logic [31:0] data; bit last; } beat_t;
  beat_t exp_q[$];

  typedef struct {
    bit dc; logic [2:0] t; logic [31:0] a; int n; logic [31:0] d0; int stall; bit exp_err;
  } rd_vec_t;
  rd_vec_t vec [6];

  localparam logic [127:0] WD1 = 128'hAABBCCDD_EEFF0011_22334455_66778899;
  localparam logic [127:0] WD2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Return-beat scoreboard: every beat the memory drives must land on the expected owner only.
  always begin : monitor
    beat_t e;
    @(negedge clk);
    #2;
    if (!reset) begin
      if (bus.ic_rd_rdy) ic_rdy_cnt++;
      if (bus.dc_rd_rdy) dc_rdy_cnt++;
      if (bus.dbg_proto_err) err_cnt++;
      chk("rdy_exclusive", bus.ic_rd_rdy & bus.dc_rd_rdy, 0);
      if (bus.m_ret_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ret_ic_valid", bus.ic_ret_valid, !e.dc);
        chk("ret_dc_valid", bus.dc_ret_valid, e.dc);
        chk("ret_data", e.dc ? bus.dc_ret_data : bus.ic_ret_data, e.data);
        chk("ret_last", e.dc ? bus.dc_ret_last : bus.ic_ret_last, e.last);
      end else begin
        chk("ret_stray", {bus.ic_ret_valid, bus.dc_ret_valid}, 0);
      end
    end
  end

  task automatic rd_request(input bit dc, input logic [2:0] t, input logic [31:0] a);
    bit got = 1'b0;
    @(negedge clk);
    if (dc) begin bus.dc_rd_req = 1; bus.dc_rd_type = t; bus.dc_rd_addr = a; end
    else    begin bus.ic_rd_req = 1; bus.ic_rd_type = t; bus.ic_rd_addr = a; end
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      got = dc ? bus.dc_rd_rdy : bus.ic_rd_rdy;
      @(negedge clk);
    end
    if (dc) bus.dc_rd_req = 0; else bus.ic_rd_req = 0;
    chk("rd_grant", got, 1);
  endtask

  task automatic mem_read(input logic [31:0] a, input logic [2:0] t, input int n,
                          input logic [31:0] d0, input bit dc, input int stall);
    bit seen = 1'b0;
    logic [31:0] dv;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = bus.m_rd_req;
    end
    chk("m_rd_req_seen", seen, 1);
    if (!seen) return;
    chk("m_rd_addr", bus.m_rd_addr, a);
    chk("m_rd_type", bus.m_rd_type, t);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("stall_req", bus.m_rd_req, 1);
      chk("stall_addr", bus.m_rd_addr, a);
    end
    bus.m_rd_rdy = 1;
    @(negedge clk);
    bus.m_rd_rdy = 0;
    for (int b = 0; b < n; b++) begin
      dv = d0 * 32'(b + 1);
      bus.m_ret_valid = 1;
      bus.m_ret_last  = (b == n - 1);
      bus.m_ret_data  = dv;
      exp_q.push_back('{dc, dv, b == n - 1});
      @(negedge clk);
    end
    bus.m_ret_valid = 0;
    bus.m_ret_last  = 0;
    bus.m_ret_data  = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ic_rd_rdy"}, bus.ic_rd_rdy, 0);
    chk({tag, "_dc_rd_rdy"}, bus.dc_rd_rdy, 0);
    chk({tag, "_ic_ret"}, {bus.ic_ret_valid, bus.ic_ret_last, bus.ic_ret_data}, 0);
    chk({tag, "_dc_ret"}, {bus.dc_ret_valid, bus.dc_ret_last, bus.dc_ret_data}, 0);
    chk({tag, "_dc_wr_rdy"}, bus.dc_wr_rdy, 0);
    chk({tag, "_m_rd"}, {bus.m_rd_req, bus.m_rd_type, bus.m_rd_addr}, 0);
    chk({tag, "_m_wr"}, {bus.m_wr_req, bus.m_wr_type, bus.m_wr_addr, bus.m_wr_wstrb}, 0);
    chk({tag, "_m_wr_data"}, bus.m_wr_data, 0);
    chk({tag, "_proto_err"}, bus.dbg_proto_err, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ic0, dc0, e0;
    vec[0] = '{1'b0, 3'b100, 32'h1c000000, 4, 32'h00000011, 0, 1'b0};
    vec[1] = '{1'b1, 3'b000, 32'h00000040, 1, 32'h5a5a0001, 0, 1'b0};
    vec[2] = '{1'b1, 3'b100, 32'h00000800, 4, 32'h01010101, 5, 1'b0};
    vec[3] = '{1'b0, 3'b010, 32'h00000104, 1, 32'hcafe0000, 2, 1'b0};
    vec[4] = '{1'b1, 3'b100, 32'h00000900, 2, 32'h00000077, 0, 1'b1};
    vec[5] = '{1'b0, 3'b000, 32'h00000a00, 3, 32'h00000005, 0, 1'b1};

    {bus.ic_rd_req, bus.ic_rd_type, bus.ic_rd_addr} = '0;
    {bus.dc_rd_req, bus.dc_rd_type, bus.dc_rd_addr} = '0;
    {bus.dc_wr_req, bus.dc_wr_type, bus.dc_wr_addr, bus.dc_wr_wstrb} = '0;
    bus.dc_wr_data = '0;
    {bus.m_rd_rdy, bus.m_ret_valid, bus.m_ret_last, bus.m_ret_data} = '0;
    {bus.m_wr_rdy, bus.m_wr_done} = '0;

    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    reset = 0;
    #1 chk("wr_rdy_after_reset", bus.dc_wr_rdy, 1);

    // Table-driven single reads.
    foreach (vec[i]) begin
      ic0 = ic_rdy_cnt; dc0 = dc_rdy_cnt; e0 = err_cnt;
      fork
        rd_request(vec[i].dc, vec[i].t, vec[i].a);
        mem_read(vec[i].a, vec[i].t, vec[i].n, vec[i].d0, vec[i].dc, vec[i].stall);
      join
      repeat (2) @(negedge clk);
      chk("vec_own_rdy_pulses", vec[i].dc ? dc_rdy_cnt - dc0 : ic_rdy_cnt - ic0, 1);
      chk("vec_other_rdy_pulses", vec[i].dc ? ic_rdy_cnt - ic0 : dc_rdy_cnt - dc0, 0);
      chk("vec_proto_err", err_cnt - e0, vec[i].exp_err);
      $display("read vec %0d: %s type=%0b addr=%08h beats=%0d stall=%0d", i,
               vec[i].dc ? "dcache" : "icache", vec[i].t, vec[i].a, vec[i].n, vec[i].stall);
    end

    // Simultaneous requests: dcache wins the first tie; the second tie depends on the mode.
    @(negedge clk);
    bus.ic_rd_req = 1; bus.ic_rd_type = 3'b100; bus.ic_rd_addr = 32'h100;
    bus.dc_rd_req = 1; bus.dc_rd_type = 3'b100; bus.dc_rd_addr = 32'h200;
    #1;
    chk("tie1_dc_rdy", bus.dc_rd_rdy, 1);
    chk("tie1_ic_rdy", bus.ic_rd_rdy, 0);
    @(negedge clk);
    bus.dc_rd_addr = 32'h300;
    mem_read(32'h200, 3'b100, 4, 32'h20, 1'b1, 0);
    #1;
    chk("tie2_dc_rdy", bus.dc_rd_rdy, SECOND_DC);
    chk("tie2_ic_rdy", bus.ic_rd_rdy, !SECOND_DC);
    @(negedge clk);
    if (SECOND_DC) bus.dc_rd_req = 0; else bus.ic_rd_req = 0;
    mem_read(SECOND_DC ? 32'h300 : 32'h100, 3'b100, 4, SECOND_DC ? 32'h30 : 32'h10, SECOND_DC, 0);
    #1;
    chk("tie3_dc_rdy", bus.dc_rd_rdy, !SECOND_DC);
    chk("tie3_ic_rdy", bus.ic_rd_rdy, SECOND_DC);
    @(negedge clk);
    bus.dc_rd_req = 0; bus.ic_rd_req = 0;
    mem_read(SECOND_DC ? 32'h100 : 32'h300, 3'b100, 4, SECOND_DC ? 32'h10 : 32'h30, !SECOND_DC, 0);
    $display("tie sequence done (second winner %s)", SECOND_DC ? "dcache" : "icache");

    // Buffered write with a slow response, overtaking read and a blocked same-line read.
    @(negedge clk);
    bus.dc_wr_req = 1; bus.dc_wr_type = 3'b100; bus.dc_wr_addr = 32'h00001230;
    bus.dc_wr_wstrb = 4'hf; bus.dc_wr_data = WD1;
    #1 chk("wr1_rdy", bus.dc_wr_rdy, 1);
    @(negedge clk);
    bus.dc_wr_req = 0;
    #1;
    chk("wr1_m_wr_req", bus.m_wr_req, 1);
    chk("wr1_m_wr_addr", bus.m_wr_addr, 32'h00001230);
    chk("wr1_m_wr_data", bus.m_wr_data, WD1);
    chk("wr1_m_wr_meta", {bus.m_wr_type, bus.m_wr_wstrb}, {3'b100, 4'hf});
    chk("wr1_busy_rdy", bus.dc_wr_rdy, 0);
    fork
      rd_request(1'b1, 3'b000, 32'h00002000);
      mem_read(32'h00002000, 3'b000, 1, 32'h77, 1'b1, 0);
    join
    @(negedge clk);
    bus.dc_rd_req = 1; bus.dc_rd_type = 3'b000; bus.dc_rd_addr = 32'h00001238;
    bus.m_wr_done = 1;
    #1 chk("haz_blocked_wreq", bus.dc_rd_rdy, 0);
    @(negedge clk);
    bus.m_wr_done = 0;
    #1;
    chk("done_in_wreq_ignored", bus.m_wr_req, 1);
    bus.m_wr_rdy = 1;
    @(negedge clk);
    bus.m_wr_rdy = 0;
    bus.dc_wr_req = 1; bus.dc_wr_addr = 32'h00003000; bus.dc_wr_data = WD2; bus.dc_wr_wstrb = 4'h3;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("resp_wait_dc_rd_rdy", bus.dc_rd_rdy, 0);
      chk("resp_wait_m_rd_req", bus.m_rd_req, 0);
      chk("resp_wait_dc_wr_rdy", bus.dc_wr_rdy, 0);
      chk("resp_wait_m_wr_req", bus.m_wr_req, 0);
      @(negedge clk);
    end
    bus.m_wr_done = 1;
    #1 chk("done_cycle_dc_rd_rdy", bus.dc_rd_rdy, 0);
    @(negedge clk);
    bus.m_wr_done = 0;
    #1;
    chk("after_done_dc_wr_rdy", bus.dc_wr_rdy, 1);
    chk("after_done_dc_rd_rdy", bus.dc_rd_rdy, 1);
    @(negedge clk);
    bus.dc_wr_req = 0; bus.dc_rd_req = 0;
    #1;
    chk("wr2_m_wr_addr", bus.m_wr_addr, 32'h00003000);
    chk("wr2_m_wr_data", bus.m_wr_data, WD2);
    chk("wr2_m_wr_wstrb", bus.m_wr_wstrb, 4'h3);
    mem_read(32'h00001238, 3'b000, 1, 32'h99, 1'b1, 0);
    bus.m_wr_rdy = 1;
    @(negedge clk);
    bus.m_wr_rdy = 0; bus.m_wr_done = 1;
    @(negedge clk);
    bus.m_wr_done = 0;
    $display("write hazard sequence done");

    // Write and same-line read in one cycle: write wins, read waits for the write to finish.
    @(negedge clk);
    bus.dc_wr_req = 1; bus.dc_wr_addr = 32'h00004000; bus.dc_wr_data = WD1; bus.dc_wr_wstrb = 4'hf;
    bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h00004008; bus.dc_rd_type = 3'b000;
    #1;
    chk("same_cycle_wr_rdy", bus.dc_wr_rdy, 1);
    chk("same_cycle_rd_rdy", bus.dc_rd_rdy, 0);
    @(negedge clk);
    bus.dc_wr_req = 0;
    #1 chk("same_line_wreq_rd_rdy", bus.dc_rd_rdy, 0);
    bus.m_wr_rdy = 1;
    @(negedge clk);
    bus.m_wr_rdy = 0; bus.m_wr_done = 1;
    #1 chk("same_line_wresp_rd_rdy", bus.dc_rd_rdy, 0);
    @(negedge clk);
    bus.m_wr_done = 0;
    #1 chk("same_line_released_rd_rdy", bus.dc_rd_rdy, 1);
    @(negedge clk);
    bus.dc_rd_req = 0;
    mem_read(32'h00004008, 3'b000, 1, 32'h44, 1'b1, 0);
    $display("simultaneous write/read sequence done");

    // Reset in the middle of a line return; stray beats afterwards must be dropped.
    @(negedge clk);
    bus.ic_rd_req = 1; bus.ic_rd_type = 3'b100; bus.ic_rd_addr = 32'h00000500;
    #1 chk("rst_seq_ic_rdy", bus.ic_rd_rdy, 1);
    @(negedge clk);
    bus.ic_rd_req = 0;
    #1 chk("rst_seq_m_rd_req", bus.m_rd_req, 1);
    bus.m_rd_rdy = 1;
    @(negedge clk);
    bus.m_rd_rdy = 0;
    for (int b = 0; b < 2; b++) begin
      bus.m_ret_valid = 1; bus.m_ret_last = 0; bus.m_ret_data = 32'h0000b000 + 32'(b);
      exp_q.push_back('{1'b0, 32'h0000b000 + 32'(b), 1'b0});
      @(negedge clk);
    end
    bus.m_ret_valid = 0;
    reset = 1;
    bus.ic_rd_req = 1;
    @(negedge clk);
    #1 check_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 0; bus.ic_rd_req = 0;
    bus.m_ret_valid = 1; bus.m_ret_last = 1; bus.m_ret_data = 32'hdeadbeef;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stray_ic_ret_valid", bus.ic_ret_valid, 0);
      chk("stray_dc_ret_valid", bus.dc_ret_valid, 0);
      chk("stray_m_rd_req", bus.m_rd_req, 0);
      @(negedge clk);
    end
    bus.m_ret_valid = 0; bus.m_ret_last = 0; bus.m_ret_data = '0;
    $display("reset mid-burst sequence done");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
